// File: rtl/dice_pkg.sv
// Shared die codes, face-count lookup and FSM state encoding for the dice roll arbiter.
package dice_pkg;

    typedef enum logic [1:0] {
        D4  = 2'b00,
        D6  = 2'b01,
        D8  = 2'b10,
        D20 = 2'b11
    } die_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture,
        StResp
    } state_e;

    function automatic logic [7:0] faces(input logic [1:0] code);
        logic [7:0] f;
        f = 8'd4;
        unique case (die_e'(code))
            D4:  f = 8'd4;
            D6:  f = 8'd6;
            D8:  f = 8'd8;
            D20: f = 8'd20;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dice_roll_arbiter_rr.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         index,
    output logic               found
);

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        // Outer loop is search order from the pointer; inner loop keeps indices constant.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && (k == (32'(pointer) + i) % NUM_REQ) && req[k]) begin
                    found    = 1'b1;
                    index    = 3'(k);
                    grant[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dice_roll_arbiter.sv
// Shares one dice_roller between NUM_REQ requesters: round-robin grant, roll pulse,
// result capture with range check, and a valid/ready response.
module dice_roll_arbiter
    import dice_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned RESULT_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_die,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [7:0]           rsp_value,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [1:0]           die_select,
    output logic                 roll,
    input  logic [7:0]           rolled_number
);

    localparam logic [1:0] WaitLast = 2'(RESULT_LATENCY > 1 ? RESULT_LATENCY - 2 : 0);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] win_q, win_d;
    logic [1:0] die_q, die_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] id_q, id_d;
    logic [7:0] val_q, val_d;
    logic       err_q, err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [2:0]         arb_index;
    logic               arb_found;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req    (req),
        .pointer(ptr_q),
        .grant  (arb_grant),
        .index  (arb_index),
        .found  (arb_found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        die_d   = die_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        val_d   = val_q;
        err_d   = err_q;
        grant   = '0;
        roll    = 1'b0;

        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    grant = arb_grant;
                    win_d = arb_index;
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        if (arb_grant[k]) begin
                            die_d = req_die[2*k +: 2];
                        end
                    end
                    ptr_d   = (arb_index == 3'(NUM_REQ - 1)) ? 3'd0 : arb_index + 3'd1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                roll    = 1'b1;
                cnt_d   = '0;
                state_d = (RESULT_LATENCY > 1) ? StWait : StCapture;
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StCapture: begin
                val_d   = rolled_number;
                id_d    = win_q;
                err_d   = (rolled_number == 8'd0) || (rolled_number > faces(die_q));
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset must kill the combinational pulses in the very cycle it is seen.
        if (reset) begin
            grant = '0;
            roll  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            die_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            die_q   <= die_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid  = (state_q == StResp);
    assign busy       = (state_q != StIdle);
    assign rsp_id     = id_q;
    assign rsp_value  = val_q;
    assign rsp_err    = err_q;
    assign die_select = die_q;

endmodule
